// File: rtl/serial_pkg.sv
// Shared types and constants for the serial library (uart_tx / uart_rx).
package serial_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, received byte and status pulses out.
interface uart_rx_if;
    import serial_pkg::*;

    logic                      rx;
    logic [UART_DATA_BITS-1:0] data;
    logic                      valid;
    logic                      frame_err;
    logic                      busy;

    modport master (
        output rx,
        input  data,
        input  valid,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  rx,
        output data,
        output valid,
        output frame_err,
        output busy
    );

endinterface

// File: rtl/bit_sync.sv
// Two-flop synchroniser for a single asynchronous level; reset value is selectable.
module bit_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= {2{RST_VAL}};
        end else begin
            r_sync <= {r_sync[0], i_d};
        end
    end

    assign o_q = r_sync[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: centre-samples each bit after locating the start-bit middle.
//
// state | meaning
// IDLE  | line idle, waiting for rx_s low
// START | counting to start-bit centre, re-checking the low
// DATA  | sampling 8 data bits LSB first at each bit centre
// STOP  | sampling stop bit; good -> valid, low -> frame_err
// BREAK | stop was low, waiting for line to return high
module uart_rx
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.slave  rx_if
);

    localparam int             CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]  BIT_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     LAST_IDX = 3'(UART_DATA_BITS - 1);

    uart_rx_state_t            r_state;
    logic [CW-1:0]             r_cnt;
    logic [2:0]                r_bit_idx;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic [UART_DATA_BITS-1:0] r_data;
    logic                      r_valid;
    logic                      r_frame_err;

    uart_rx_state_t            w_state_nxt;
    logic [CW-1:0]             w_cnt_nxt;
    logic [2:0]                w_bit_idx_nxt;
    logic [UART_DATA_BITS-1:0] w_shift_nxt;
    logic [UART_DATA_BITS-1:0] w_data_nxt;
    logic                      w_valid_nxt;
    logic                      w_frame_err_nxt;
    logic                      w_rx_s;

    bit_sync #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (rx_if.rx),
        .o_q (w_rx_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_data      <= w_data_nxt;
            r_valid     <= w_valid_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_bit_idx_nxt   = r_bit_idx;
        w_shift_nxt     = r_shift;
        w_data_nxt      = r_data;
        w_valid_nxt     = 1'b0;
        w_frame_err_nxt = 1'b0;

        case (r_state)
            IDLE: begin
                if (!w_rx_s) begin
                    w_state_nxt = START;
                    w_cnt_nxt   = '0;
                end
            end

            START: begin
                if (r_cnt == HALF_M1) begin
                    w_cnt_nxt = '0;
                    // A low that does not survive to the start-bit centre is a glitch.
                    if (!w_rx_s) begin
                        w_state_nxt   = DATA;
                        w_bit_idx_nxt = '0;
                    end else begin
                        w_state_nxt   = IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end

            DATA: begin
                if (r_cnt == BIT_M1) begin
                    w_shift_nxt[r_bit_idx] = w_rx_s;
                    w_cnt_nxt              = '0;
                    if (r_bit_idx == LAST_IDX) begin
                        w_state_nxt = STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end

            STOP: begin
                if (r_cnt == BIT_M1) begin
                    w_cnt_nxt = '0;
                    if (w_rx_s) begin
                        w_data_nxt  = r_shift;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_frame_err_nxt = 1'b1;
                        w_state_nxt     = BREAK;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end

            BREAK: begin
                if (w_rx_s) begin
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign rx_if.data      = r_data;
    assign rx_if.valid     = r_valid;
    assign rx_if.frame_err = r_frame_err;
    assign rx_if.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: vector table, corner-case sequences and random frames.
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
    // Negedge index of the output pulse, relative to the negedge that drives the start bit low:
    // stop-sample edge is e(2+HALF+9*CPB), and e0 is one posedge after the driving negedge.
    localparam int PULSE_LAT = 1 + 2 + HALF + 9 * CPB;

    typedef struct {
        int         cyc;
        bit         v;
        bit         fe;
        logic [7:0] d;
    } ev_t;

    typedef struct {
        logic [7:0] b;
        bit         stop_ok;
        int         gap;
        bit         exp_v;
        bit         exp_fe;
        logic [7:0] exp_d;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic prev_busy = 1'b0;
    logic [7:0] ref_data;
    ev_t  ev_q[$];
    ev_t  exp_q[$];

    uart_rx_if u_if ();

    uart_rx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .rx_if (u_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Pulse monitor: records every valid/frame_err cycle and checks the per-pulse rules.
    always @(negedge clk) begin
        if (!rst && (u_if.valid || u_if.frame_err)) begin
            ev_q.push_back(ev_t'{cyc, u_if.valid, u_if.frame_err, u_if.data});
            check("pulse_exclusive", {31'd0, u_if.valid & u_if.frame_err}, 32'd0);
            check("pulse_busy_now", {31'd0, u_if.busy}, {31'd0, u_if.frame_err});
            check("pulse_busy_before", {31'd0, prev_busy}, 32'd1);
        end
        prev_busy = u_if.busy;
    end

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, output int t0);
        t0 = cyc;
        u_if.rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            u_if.rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        u_if.rx = stop_ok;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle(input int n);
        u_if.rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Reference model: a good stop publishes the byte; a bad stop flags and keeps the old byte.
    task automatic model_frame(input logic [7:0] b, input bit stop_ok, input int t0);
        if (stop_ok) begin
            ref_data = b;
            exp_q.push_back(ev_t'{t0 + PULSE_LAT, 1'b1, 1'b0, b});
        end else begin
            exp_q.push_back(ev_t'{t0 + PULSE_LAT, 1'b0, 1'b1, ref_data});
        end
    endtask

    task automatic compare_events(input string tag);
        check({tag, "_count"}, ev_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
            check({tag, "_cycle"}, ev_q[i].cyc, exp_q[i].cyc);
            check({tag, "_valid"}, {31'd0, ev_q[i].v}, {31'd0, exp_q[i].v});
            check({tag, "_frame_err"}, {31'd0, ev_q[i].fe}, {31'd0, exp_q[i].fe});
            check({tag, "_data"}, {24'd0, ev_q[i].d}, {24'd0, exp_q[i].d});
        end
        ev_q.delete();
        exp_q.delete();
    endtask

    initial begin
        vec_t       vecs[6];
        int         t0;
        int         gap;
        logic [7:0] b;
        bit         ok;

        vecs[0] = '{8'h55, 1'b1, 2 * CPB, 1'b1, 1'b0, 8'h55};
        vecs[1] = '{8'h00, 1'b1, 0,       1'b1, 1'b0, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, CPB,     1'b1, 1'b0, 8'hFF};
        vecs[3] = '{8'hA5, 1'b0, CPB,     1'b0, 1'b1, 8'hFF};
        vecs[4] = '{8'h81, 1'b1, 0,       1'b1, 1'b0, 8'h81};
        vecs[5] = '{8'h7E, 1'b1, CPB,     1'b1, 1'b0, 8'h7E};

        u_if.rx = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_data", {24'd0, u_if.data}, 32'd0);
        check("reset_valid", {31'd0, u_if.valid}, 32'd0);
        check("reset_frame_err", {31'd0, u_if.frame_err}, 32'd0);
        check("reset_busy", {31'd0, u_if.busy}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_busy", {31'd0, u_if.busy}, 32'd0);
        ref_data = 8'h00;

        // Vector table: loopback 'U', back-to-back 00/FF, bad stop, more back-to-back.
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].b, vecs[i].stop_ok, t0);
            exp_q.push_back(ev_t'{t0 + PULSE_LAT, vecs[i].exp_v, vecs[i].exp_fe, vecs[i].exp_d});
            if (vecs[i].gap > 0) idle(vecs[i].gap);
        end
        idle(2 * CPB);
        compare_events("table");
        ref_data = vecs[5].exp_d;
        check("table_data_hold", {24'd0, u_if.data}, {24'd0, ref_data});

        // Glitch: 5-cycle low must be rejected.
        u_if.rx = 1'b0;
        repeat (4) @(negedge clk);
        check("glitch_busy_high", {31'd0, u_if.busy}, 32'd1);
        repeat (1) @(negedge clk);
        u_if.rx = 1'b1;
        repeat (8) @(negedge clk);
        check("glitch_busy_low", {31'd0, u_if.busy}, 32'd0);
        idle(2 * CPB);
        compare_events("glitch");
        check("glitch_data_hold", {24'd0, u_if.data}, {24'd0, ref_data});

        // Bad stop followed by a long break: one frame_err only.
        send_frame(8'hA5, 1'b0, t0);
        model_frame(8'hA5, 1'b0, t0);
        repeat (40 * CPB) @(negedge clk);
        check("break_busy", {31'd0, u_if.busy}, 32'd1);
        idle(2 * CPB);
        compare_events("break");
        check("break_data_hold", {24'd0, u_if.data}, {24'd0, ref_data});
        check("break_idle", {31'd0, u_if.busy}, 32'd0);

        // Random frames with random gaps and occasional bad stops.
        for (int i = 0; i < 24; i++) begin
            b  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 7) != 0);
            send_frame(b, ok, t0);
            model_frame(b, ok, t0);
            gap = ok ? int'($urandom_range(0, 2 * CPB)) : int'($urandom_range(2, 2 * CPB));
            if (gap > 0) idle(gap);
        end
        idle(2 * CPB);
        compare_events("random");
        check("random_data_final", {24'd0, u_if.data}, {24'd0, ref_data});

        // Reset in the middle of data bit 3 of 8'h3C, then a clean 8'hC3.
        send_frame(8'h96, 1'b1, t0);
        model_frame(8'h96, 1'b1, t0);
        idle(CPB);
        compare_events("pre_reset");
        b = 8'h3C;
        u_if.rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            u_if.rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        u_if.rx = b[3];
        repeat (HALF) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_data", {24'd0, u_if.data}, 32'd0);
        check("midrst_valid", {31'd0, u_if.valid}, 32'd0);
        check("midrst_frame_err", {31'd0, u_if.frame_err}, 32'd0);
        check("midrst_busy", {31'd0, u_if.busy}, 32'd0);
        repeat (2) @(negedge clk);
        u_if.rx = 1'b1;
        rst = 1'b0;
        ev_q.delete();
        exp_q.delete();
        ref_data = 8'h00;
        idle(4);
        send_frame(8'hC3, 1'b1, t0);
        model_frame(8'hC3, 1'b1, t0);
        idle(2 * CPB);
        compare_events("after_reset");
        check("after_reset_data", {24'd0, u_if.data}, 32'h0000_00C3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
